sticky_status_reg: RTL and testbench

- Parametrised status register for APB peripherals (I2C, SPI, UART).
- Each bit is either a registered pass-through or a sticky (set-on-event) flag.
- Sticky flags are cleared by a delayed clear-all sequence or by a per-bit write-1-to-clear.
- Adds event capture during the clear window, interrupt masking, and a busy flag; sits between the controller core and the APB slave register map.

---
 rtl/i2c_status_pkg.sv | 36 +++
 rtl/sticky_status_reg.sv | 91 +++++++++
 tb/tb_sticky_status_reg.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_status_pkg.sv
// Shared definitions for the I2C status register map: bit positions, the default
// sticky mask and the clear-sequence state encoding.
package i2c_status_pkg;

   localparam int unsigned I2C_STATUS_WIDTH = 13;
   localparam int unsigned CLR_CNT_W        = 4;
   localparam int unsigned CLR_DELAY_MAX    = (1 << CLR_CNT_W) - 1;

   // I2C status map bit positions
   localparam int unsigned BIT_ARB_LOST   = 0;
   localparam int unsigned BIT_BUS_BUSY   = 1;
   localparam int unsigned BIT_NACK       = 2;
   localparam int unsigned BIT_STOP_DET   = 3;
   localparam int unsigned BIT_SDA_HELD   = 4;
   localparam int unsigned BIT_START_DET  = 5;
   localparam int unsigned BIT_RX_OVF     = 6;
   localparam int unsigned BIT_TX_EMPTY   = 7;
   localparam int unsigned BIT_RX_FULL    = 8;
   localparam int unsigned BIT_TIMEOUT    = 9;
   localparam int unsigned BIT_SLAVE_MODE = 10;
   localparam int unsigned BIT_TX_REQ     = 11;
   localparam int unsigned BIT_GEN_CALL   = 12;

   // Event-style flags latch; level flags (bus busy, FIFO levels, mode) pass through.
   localparam logic [I2C_STATUS_WIDTH-1:0] DEFAULT_STICKY_MASK =
      I2C_STATUS_WIDTH'((1 << BIT_ARB_LOST)  | (1 << BIT_NACK)   | (1 << BIT_STOP_DET) |
                        (1 << BIT_START_DET) | (1 << BIT_RX_OVF) | (1 << BIT_TIMEOUT)  |
                        (1 << BIT_GEN_CALL));

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CLEAR = 2'd2
   } clr_state_e;

endpackage

// File: rtl/sticky_status_reg.sv
// Status register with per-bit sticky/pass-through behaviour, a delayed clear-all
// sequence that captures events arriving during the wait, W1C and masked interrupt.
module sticky_status_reg
   import i2c_status_pkg::*;
#(
   parameter int unsigned           WIDTH       = I2C_STATUS_WIDTH,
   parameter logic [WIDTH-1:0]      STICKY_MASK = WIDTH'(DEFAULT_STICKY_MASK),
   parameter int unsigned           CLEAR_DELAY = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] status_in,
   input  logic             clear,
   input  logic             w1c_en,
   input  logic [WIDTH-1:0] w1c_mask,
   input  logic [WIDTH-1:0] irq_en,
   output logic [WIDTH-1:0] status_out,
   output logic             irq,
   output logic             clear_busy
);

   if (CLEAR_DELAY > CLR_DELAY_MAX) begin : g_clear_delay_range
      $error("sticky_status_reg: CLEAR_DELAY must be in 0..15");
   end

   localparam logic [CLR_CNT_W-1:0] CNT_LOAD =
      (CLEAR_DELAY == 0) ? '0 : CLR_CNT_W'(CLEAR_DELAY - 1);
   localparam clr_state_e CLR_ENTRY = (CLEAR_DELAY == 0) ? CLEAR : WAIT;

   clr_state_e           state_q, state_d;
   logic [CLR_CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     pend_q, pend_d;
   logic [WIDTH-1:0]     sticky_d;
   logic [WIDTH-1:0]     status_d;
   logic                 irq_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      sticky_d = status_out;

      unique case (state_q)
         IDLE: begin
            // A same-cycle event wins over a W1C of that bit.
            if (w1c_en) sticky_d = (status_out & ~w1c_mask) | status_in;
            else        sticky_d = status_out | status_in;
            if (clear) begin
               state_d = CLR_ENTRY;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT: begin
            // status_out is frozen; events are parked in pend until the clear lands.
            pend_d = pend_q | (status_in & STICKY_MASK);
            if (cnt_q == '0) state_d = CLEAR;
            else             cnt_d   = cnt_q - 1'b1;
         end
         CLEAR: begin
            sticky_d = pend_q | status_in;
            pend_d   = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      status_d = (sticky_d & STICKY_MASK) | (status_in & ~STICKY_MASK);
      irq_d    = |(status_d & irq_en & STICKY_MASK);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pend_q     <= '0;
         status_out <= '0;
         irq        <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         status_out <= status_d;
         irq        <= irq_d;
      end
   end

   assign clear_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sticky_status_reg.sv
// Bench for sticky_status_reg: runs CLEAR_DELAY=2 and CLEAR_DELAY=0 instances side by side
// on shared stimulus against a cycle-level behavioural model, plus vector table and corner sequences.
module tb_sticky_status_reg;
   import i2c_status_pkg::*;

   localparam int W = 13;
   localparam logic [W-1:0] SM = 13'h126D;

   logic         clk;
   logic         n_rst;
   logic [W-1:0] status_in;
   logic         clear;
   logic         w1c_en;
   logic [W-1:0] w1c_mask;
   logic [W-1:0] irq_en;
   logic [W-1:0] st2, st0;
   logic         irq2, irq0, busy2, busy0;

   int n_vec = 0;
   int n_err = 0;

   sticky_status_reg #(.WIDTH(W), .STICKY_MASK(SM), .CLEAR_DELAY(2)) dut (
      .clk(clk), .n_rst(n_rst), .status_in(status_in), .clear(clear), .w1c_en(w1c_en),
      .w1c_mask(w1c_mask), .irq_en(irq_en), .status_out(st2), .irq(irq2), .clear_busy(busy2)
   );

   sticky_status_reg #(.WIDTH(W), .STICKY_MASK(SM), .CLEAR_DELAY(0)) dut0 (
      .clk(clk), .n_rst(n_rst), .status_in(status_in), .clear(clear), .w1c_en(w1c_en),
      .w1c_mask(w1c_mask), .irq_en(irq_en), .status_out(st0), .irq(irq0), .clear_busy(busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: busy_left counts remaining busy cycles; the last one is the clear itself.
   typedef struct {
      logic [W-1:0] st;
      logic [W-1:0] pend;
      int           busy_left;
      logic         irq;
   } model_t;

   model_t m2, m0;

   typedef struct {
      logic [W-1:0] sin;
      logic         clr;
      logic         w1c;
      logic [W-1:0] wmask;
      logic [W-1:0] ien;
      logic [W-1:0] est;
      logic         eirq;
      logic         ebusy;
   } vec_t;

   vec_t tbl[12];

   function automatic model_t model_step(model_t m, int delay, logic [W-1:0] sin, logic clr,
                                         logic w1c, logic [W-1:0] wm, logic [W-1:0] ien);
      model_t       n;
      logic [W-1:0] sticky;
      n = m;
      if (m.busy_left == 0) begin
         sticky = m.st | sin;
         if (w1c)
            for (int i = 0; i < W; i++)
               if (wm[i] && !sin[i]) sticky[i] = 1'b0;
         if (clr) n.busy_left = delay + 1;
      end else if (m.busy_left == 1) begin
         sticky      = m.pend | sin;
         n.pend      = '0;
         n.busy_left = 0;
      end else begin
         sticky      = m.st;
         n.pend      = m.pend | (sin & SM);
         n.busy_left = m.busy_left - 1;
      end
      n.st  = (sticky & SM) | (sin & ~SM);
      n.irq = |(n.st & ien & SM);
      return n;
   endfunction

   function automatic model_t model_reset();
      model_t r;
      r.st = '0; r.pend = '0; r.busy_left = 0; r.irq = 1'b0;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_models();
      check("d2_status", 32'(st2), 32'(m2.st));
      check("d2_irq",    32'(irq2), 32'(m2.irq));
      check("d2_busy",   32'(busy2), 32'(m2.busy_left > 0));
      check("d0_status", 32'(st0), 32'(m0.st));
      check("d0_irq",    32'(irq0), 32'(m0.irq));
      check("d0_busy",   32'(busy0), 32'(m0.busy_left > 0));
   endtask

   task automatic tick();
      @(posedge clk);
      m2 = model_step(m2, 2, status_in, clear, w1c_en, w1c_mask, irq_en);
      m0 = model_step(m0, 0, status_in, clear, w1c_en, w1c_mask, irq_en);
      #1;
      check_models();
   endtask

   task automatic drive(input logic [W-1:0] sin, input logic clr, input logic w1c,
                        input logic [W-1:0] wm, input logic [W-1:0] ien);
      status_in = sin; clear = clr; w1c_en = w1c; w1c_mask = wm; irq_en = ien;
   endtask

   initial begin
      tbl[0]  = '{13'h1FFF, 1'b0, 1'b0, 13'h0000, 13'h0000, 13'h1FFF, 1'b0, 1'b0};
      tbl[1]  = '{13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0000, 13'h126D, 1'b0, 1'b0};
      tbl[2]  = '{13'h0000, 1'b0, 1'b1, 13'h0009, 13'h0000, 13'h1264, 1'b0, 1'b0};
      tbl[3]  = '{13'h0002, 1'b0, 1'b0, 13'h0000, 13'h0002, 13'h1266, 1'b0, 1'b0};
      tbl[4]  = '{13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0004, 13'h1264, 1'b1, 1'b0};
      tbl[5]  = '{13'h0000, 1'b0, 1'b1, 13'h0004, 13'h0004, 13'h1260, 1'b0, 1'b0};
      tbl[6]  = '{13'h0001, 1'b0, 1'b1, 13'h0001, 13'h0000, 13'h1261, 1'b0, 1'b0};
      tbl[7]  = '{13'h0000, 1'b1, 1'b0, 13'h0000, 13'h0000, 13'h1261, 1'b0, 1'b1};
      tbl[8]  = '{13'h0000, 1'b0, 1'b1, 13'h1FFF, 13'h0000, 13'h1261, 1'b0, 1'b1};
      tbl[9]  = '{13'h0020, 1'b0, 1'b0, 13'h0000, 13'h0000, 13'h1261, 1'b0, 1'b1};
      tbl[10] = '{13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0020, 13'h0020, 1'b1, 1'b0};
      tbl[11] = '{13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0000, 13'h0020, 1'b0, 1'b0};

      // Reset held with every input bit active
      n_rst = 1'b0;
      drive(13'h1FFF, 1'b1, 1'b1, 13'h1FFF, 13'h1FFF);
      m2 = model_reset();
      m0 = model_reset();
      #3;
      check("rst_status", 32'(st2), 32'h0);
      check("rst_irq",    32'(irq2), 32'h0);
      check("rst_busy",   32'(busy2), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      check_models();
      drive(13'h0000, 1'b0, 1'b0, 13'h0000, 13'h0000);
      #2 n_rst = 1'b1;

      // Vector table against hand-derived expectations (CLEAR_DELAY=2 instance)
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].sin, tbl[i].clr, tbl[i].w1c, tbl[i].wmask, tbl[i].ien);
         tick();
         check($sformatf("tbl%0d_status", i), 32'(st2), 32'(tbl[i].est));
         check($sformatf("tbl%0d_irq", i),    32'(irq2), 32'(tbl[i].eirq));
         check($sformatf("tbl%0d_busy", i),   32'(busy2), 32'(tbl[i].ebusy));
      end

      // Sticky bit 3 set, then clear issued at t
      drive(13'h0008, 1'b0, 1'b0, 13'h0000, 13'h0000);
      tick();
      drive(13'h0000, 1'b1, 1'b0, 13'h0000, 13'h0000);
      tick();
      check("s1_t1_busy", 32'(busy2), 32'h1);
      check("s1_t1_bit3", 32'(st2[3]), 32'h1);
      check("s1_t1_busy0", 32'(busy0), 32'h1);
      clear = 1'b0;
      tick();
      check("s1_t2_bit3", 32'(st2[3]), 32'h1);
      check("s1_t2_d0_bit3", 32'(st0[3]), 32'h0);
      check("s1_t2_d0_busy", 32'(busy0), 32'h0);
      tick();
      check("s1_t3_busy", 32'(busy2), 32'h1);
      check("s1_t3_bit3", 32'(st2[3]), 32'h1);
      tick();
      check("s1_t4_bit3", 32'(st2[3]), 32'h0);
      check("s1_t4_busy", 32'(busy2), 32'h0);

      // Event on bit 5 during WAIT is captured into the post-clear value
      drive(13'h0000, 1'b1, 1'b0, 13'h0000, 13'h0020);
      tick();
      clear = 1'b0;
      tick();
      status_in = 13'h0020;
      tick();
      status_in = 13'h0000;
      check("s2_t3_bit5_frozen", 32'(st2[5]), 32'h0);
      tick();
      check("s2_t4_bit5", 32'(st2[5]), 32'h1);
      check("s2_t4_irq", 32'(irq2), 32'h1);

      // Pass-through bit never raises irq
      drive(13'h0002, 1'b0, 1'b0, 13'h0000, 13'h0002);
      tick();
      check("pt_bit1", 32'(st2[1]), 32'h1);
      check("pt_irq", 32'(irq0), 32'(m0.irq));

      // Reset asserted mid-sequence
      drive(13'h0000, 1'b1, 1'b0, 13'h0000, 13'h1FFF);
      tick();
      clear = 1'b0;
      tick();
      #2 n_rst = 1'b0;
      #1;
      m2 = model_reset();
      m0 = model_reset();
      check("mrst_status", 32'(st2), 32'h0);
      check("mrst_irq",    32'(irq2), 32'h0);
      check("mrst_busy",   32'(busy2), 32'h0);
      check_models();
      #1 n_rst = 1'b1;
      tick();

      // Randomised stimulus against the model
      for (int i = 0; i < 400; i++) begin
         drive(W'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
               W'($urandom), W'($urandom));
         if ($urandom_range(0, 3) != 0) status_in = status_in & W'($urandom) & W'($urandom);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
